// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller
// Scans a 4x4 matrix keypad one column at a time and debounces both press
// and release. Emits a single-cycle strobe carrying the hex code of each
// accepted key. While a key is tracked, its column stays driven.
module keypad_scan_controller #(
  parameter int SCAN_COUNT     = 192000,
  parameter int DEBOUNCE_COUNT = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypad_hori,
  output logic [3:0] keypad_vert,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAXC = (SCAN_COUNT > DEBOUNCE_COUNT) ? SCAN_COUNT : DEBOUNCE_COUNT;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_COUNT - 1);
  localparam logic [CW-1:0] PRESS_LAST = CW'(DEBOUNCE_COUNT - 1);
  // The HELD cycle that first sees the row high counts as one stable
  // sample, so DB_REL needs one fewer.
  localparam logic [CW-1:0] REL_LAST   = CW'(DEBOUNCE_COUNT - 2);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DB_PRESS = 2'd1,
    ST_HELD     = 2'd2,
    ST_DB_REL   = 2'd3
  } state_t;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  state_t        r_state;
  logic [1:0]    r_col;
  logic [1:0]    r_row;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_code;
  logic          r_valid;
  logic          r_held;

  state_t        w_state_next;
  logic [1:0]    w_col_next;
  logic [1:0]    w_row_next;
  logic [CW-1:0] w_cnt_next;
  logic [3:0]    w_code_next;
  logic          w_valid_next;
  logic          w_held_next;

  logic          w_one_low;
  logic [1:0]    w_hit_row;
  logic [3:0]    w_pattern;
  logic          w_row_high;

  // Row/column to hex code lookup.
  function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous row rails.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= keypad_hori;
      r_sync2 <= r_sync1;
    end
  end

  // Decode the synced rows: exactly-one-low detection and latched-row views.
  always_comb begin
    w_one_low = 1'b1;
    w_hit_row = 2'd0;
    case (r_sync2)
      4'b1110: w_hit_row = 2'd0;
      4'b1101: w_hit_row = 2'd1;
      4'b1011: w_hit_row = 2'd2;
      4'b0111: w_hit_row = 2'd3;
      default: w_one_low = 1'b0;
    endcase
    w_pattern  = ~(4'b0001 << r_row);
    w_row_high = r_sync2[r_row];
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_SCAN;
      r_col   <= 2'd0;
      r_row   <= 2'd0;
      r_cnt   <= '0;
      r_code  <= 4'h0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
      r_cnt   <= w_cnt_next;
      r_code  <= w_code_next;
      r_valid <= w_valid_next;
      r_held  <= w_held_next;
    end
  end

  // Next-state logic: scan dwell, press debounce, hold, release debounce.
  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_cnt_next   = r_cnt;
    w_code_next  = r_code;
    w_valid_next = 1'b0;
    w_held_next  = r_held;
    case (r_state)
      ST_SCAN: begin
        if (r_cnt == SCAN_LAST) begin
          w_cnt_next = '0;
          if (w_one_low) begin
            w_row_next   = w_hit_row;
            w_state_next = ST_DB_PRESS;
          end else begin
            w_col_next = r_col + 2'd1;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ST_DB_PRESS: begin
        if (r_sync2 != w_pattern) begin
          w_state_next = ST_SCAN;
          w_col_next   = r_col + 2'd1;
          w_cnt_next   = '0;
        end else if (r_cnt == PRESS_LAST) begin
          w_state_next = ST_HELD;
          w_valid_next = 1'b1;
          w_code_next  = map_key(r_row, r_col);
          w_held_next  = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (w_row_high) begin
          w_cnt_next   = '0;
          w_state_next = ST_DB_REL;
        end
      end
      ST_DB_REL: begin
        if (!w_row_high) begin
          w_state_next = ST_HELD;
        end else if (r_cnt == REL_LAST) begin
          w_held_next  = 1'b0;
          w_col_next   = r_col + 2'd1;
          w_state_next = ST_SCAN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: w_state_next = ST_SCAN;
    endcase
  end

  // Outputs: active-low one-hot column drive plus registered key outputs.
  always_comb begin
    keypad_vert = ~(4'b0001 << r_col);
    key_code    = r_code;
    key_valid   = r_valid;
    key_held    = r_held;
  end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller: a key-matrix model drives the row rails
// from the column drive, and a behavioural model counts stable samples to
// predict every output on every cycle.
module tb_keypad_scan_controller;

  localparam int SC = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keypad_hori;
  logic [3:0] keypad_vert;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c is down
  logic [3:0]  keymap [16];

  int checks  = 0;
  int errors  = 0;
  int strobes = 0;

  always #5 clk = ~clk;

  keypad_scan_controller #(.SCAN_COUNT(SC), .DEBOUNCE_COUNT(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .keypad_hori(keypad_hori),
    .keypad_vert(keypad_vert),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  // Physical matrix: a row rail is pulled low by any pressed key whose column is driven low.
  function automatic logic [3:0] rows_for(input logic [15:0] p, input logic [3:0] vert);
    logic [3:0] h;
    h = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (p[r*4+c] && !vert[c]) h[r] = 1'b0;
    return h;
  endfunction

  always_comb keypad_hori = rows_for(pressed, keypad_vert);

  // ---------------- behavioural model ----------------
  // mode: 0 scanning, 1 confirming press, 2 key down, 3 confirming release
  int         m_mode, m_col, m_dwell, m_row, m_run;
  logic [3:0] m_s1, m_s2, m_code;
  logic       m_valid, m_held;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= 0; m_col <= 0; m_dwell <= 0; m_row <= 0; m_run <= 0;
      m_s1 <= 4'hF; m_s2 <= 4'hF; m_code <= 4'h0; m_valid <= 1'b0; m_held <= 1'b0;
    end else begin : step
      int mode, col, dwell, row, run, lows, cand;
      logic [3:0] code, seen, pat;
      logic valid, held;
      mode = m_mode; col = m_col; dwell = m_dwell; row = m_row; run = m_run;
      code = m_code; held = m_held; valid = 1'b0;
      seen = m_s2;
      case (mode)
        0: begin
          dwell = dwell + 1;
          if (dwell == SC) begin
            dwell = 0;
            lows = 0; cand = 0;
            for (int r = 0; r < 4; r++) if (!seen[r]) begin lows++; cand = r; end
            if (lows == 1) begin row = cand; mode = 1; run = 1; end
            else col = (col + 1) % 4;
          end
        end
        1: begin
          pat = 4'hF; pat[row] = 1'b0;
          if (seen == pat) begin
            run = run + 1;
            if (run == DB + 1) begin
              valid = 1'b1; held = 1'b1; code = keymap[row*4+col]; mode = 2;
            end
          end else begin
            mode = 0; col = (col + 1) % 4; dwell = 0;
          end
        end
        2: if (seen[row]) begin mode = 3; run = 1; end
        3: begin
          if (seen[row]) begin
            run = run + 1;
            if (run == DB) begin held = 1'b0; mode = 0; dwell = 0; col = (col + 1) % 4; end
          end else mode = 2;
        end
        default: mode = 0;
      endcase
      m_s2 <= m_s1;
      m_s1 <= rows_for(pressed, ~(4'b0001 << m_col));
      m_mode <= mode; m_col <= col; m_dwell <= dwell; m_row <= row; m_run <= run;
      m_code <= code; m_valid <= valid; m_held <= held;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin : cmp
    logic [3:0] ev;
    ev = ~(4'b0001 << m_col);
    checks++;
    if (keypad_vert !== ev || key_code !== m_code || key_valid !== m_valid || key_held !== m_held) begin
      errors++;
      if (errors < 30)
        $display("FAIL cycle t=%0t vert=%b exp=%b code=%h exp=%h valid=%b exp=%b held=%b exp=%b",
                 $time, keypad_vert, ev, key_code, m_code, key_valid, m_valid, key_held, m_held);
    end
    if (key_valid === 1'b1) strobes++;
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_released(input string name, input int budget);
    int n;
    n = 0;
    while (key_held !== 1'b0 && n < budget) begin tick(1); n++; end
    checks++;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL %s release timeout actual=%b expected=0", name, key_held);
    end
  endtask

  task automatic reset_values(input string name);
    check({name, "_vert"},  int'(keypad_vert), 4'b1110);
    check({name, "_code"},  int'(key_code), 0);
    check({name, "_valid"}, int'(key_valid), 0);
    check({name, "_held"},  int'(key_held), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0, s1, n, k, nb, hold, gap;
    bit do_rst;
    keymap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    reset = 1'b0;
    tick(3);
    reset_values("reset");
    reset = 1'b1;

    // Idle scan, no keys.
    s0 = strobes;
    tick(40);
    check("idle_strobes", strobes - s0, 0);
    $display("TXN idle strobes=%0d", strobes - s0);

    // Key 8 (r2,c1).
    s0 = strobes;
    pressed[2*4+1] = 1'b1;
    tick(40);
    check("key8_strobes", strobes - s0, 1);
    check("key8_code", int'(key_code), 8);
    check("key8_held", int'(key_held), 1);
    check("key8_vert", int'(keypad_vert), 4'b1101);
    pressed = '0;
    wait_released("key8", 40);
    check("key8_next_col", int'(keypad_vert), 4'b1011);
    $display("TXN key8 code=%h strobes=%0d", key_code, strobes - s0);

    // Press bounce on key A (r0,c3).
    s0 = strobes;
    for (int i = 0; i < 10; i++) begin pressed[3] = ~pressed[3]; tick(3); end
    check("bounce_none", strobes - s0, 0);
    pressed[3] = 1'b1;
    tick(40);
    check("bounce_strobes", strobes - s0, 1);
    check("bounce_code", int'(key_code), 4'hA);
    pressed = '0;
    wait_released("keyA", 40);
    $display("TXN keyA code=%h strobes=%0d", key_code, strobes - s0);

    // Release bounce on key 0 (r3,c1).
    s0 = strobes;
    pressed[3*4+1] = 1'b1;
    tick(40);
    check("key0_code", int'(key_code), 0);
    check("key0_strobes", strobes - s0, 1);
    s1 = strobes;
    pressed = '0; tick(5);
    pressed[3*4+1] = 1'b1; tick(2);
    pressed = '0;
    wait_released("key0", 60);
    check("key0_rel_strobes", strobes - s1, 0);
    $display("TXN key0 code=%h strobes=%0d", key_code, strobes - s0);

    // Two rows low in column 0.
    s0 = strobes;
    pressed[1*4+0] = 1'b1; pressed[2*4+0] = 1'b1;
    tick(30);
    check("multi_strobes", strobes - s0, 0);
    pressed = '0;
    tick(5);
    $display("TXN multi strobes=%0d", strobes - s0);

    // Hold F, press another key in a different column.
    s0 = strobes;
    pressed[3*4+2] = 1'b1;
    tick(40);
    check("F_code", int'(key_code), 4'hF);
    s1 = strobes;
    pressed[0] = 1'b1;
    tick(20);
    check("F_other_strobes", strobes - s1, 0);
    check("F_code_kept", int'(key_code), 4'hF);
    pressed[0] = 1'b0; tick(2);
    pressed = '0;
    wait_released("keyF", 40);
    $display("TXN keyF code=%h strobes=%0d", key_code, strobes - s0);

    // Reset during press debounce (count 5), key 6 (r1,c2).
    pressed[1*4+2] = 1'b1;
    n = 0;
    while (!(m_mode == 1 && m_run == 6) && n < 60) begin tick(1); n++; end
    check("rst_reach_debounce", int'(m_mode == 1 && m_run == 6), 1);
    s0 = strobes;
    reset = 1'b0;
    #1;
    reset_values("midreset");
    tick(3);
    reset = 1'b1;
    tick(40);
    check("rst_strobes", strobes - s0, 1);
    check("rst_code", int'(key_code), 6);
    pressed = '0;
    wait_released("key6", 40);
    $display("TXN key6-after-reset code=%h strobes=%0d", key_code, strobes - s0);

    // Randomized presses with bounce on both edges.
    for (int t = 0; t < 25; t++) begin
      k = $urandom_range(0, 15);
      do_rst = ($urandom_range(0, 5) == 0);
      s0 = strobes;
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        pressed[k] = 1'b1; tick($urandom_range(1, 4));
        pressed[k] = 1'b0; tick($urandom_range(1, 4));
      end
      pressed[k] = 1'b1;
      hold = $urandom_range(30, 60);
      tick(hold);
      if (do_rst) begin
        reset = 1'b0; tick(2); reset = 1'b1; tick(40);
      end
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        pressed[k] = 1'b0; tick($urandom_range(1, 4));
        pressed[k] = 1'b1; tick($urandom_range(1, 4));
      end
      pressed = '0;
      wait_released("rand", 100);
      check("rand_strobes", strobes - s0, do_rst ? 2 : 1);
      check("rand_code", int'(key_code), int'(keymap[k]));
      gap = $urandom_range(5, 20);
      tick(gap);
      $display("TXN rand %0d key=%0d code=%h reset=%0d strobes=%0d", t, k, key_code, do_rst, strobes - s0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
